// File: rtl/pcpu_mem_arbiter_if.sv
// pcpu_mem_arbiter_if: CPU fetch/data requester and unified-memory signals seen by the arbiter.
interface pcpu_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_ctrl;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_ctrl;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        err;
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_ctrl, m_ack, m_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, m_req, m_we, m_addr, m_wdata, m_ctrl, err
    );
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_ctrl, m_ack, m_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, m_req, m_we, m_addr, m_wdata, m_ctrl, err
    );
endinterface

// File: rtl/pcpu_mem_arbiter.sv
// pcpu_mem_arbiter: round-robin IF/data arbiter for one variable-latency memory port with watchdog.
module pcpu_mem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic               clk,
    input logic               reset,
    pcpu_mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
    logic [1:0]       state_q, state_d;
    logic             m_req_q, m_req_d, m_we_q, m_we_d;
    logic [31:0]      m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic [2:0]       m_ctrl_q, m_ctrl_d;
    logic             if_ready_q, if_ready_d, d_ready_q, d_ready_d, err_q, err_d;
    logic [31:0]      if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic             owner_q, owner_d, last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt, tmo;
    // Data wins a tie unless it owned the previous grant (owner/last: 1 = data).
    assign gnt = bus.d_req & (~bus.if_req | ~last_q);
    assign tmo = (TIMEOUT != 0) && (cnt_q == LIM);
    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_ctrl_d   = m_ctrl_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        if (state_q == IDLE) begin
            if (bus.if_req | bus.d_req) begin
                state_d   = BUSY;
                m_req_d   = 1'b1;
                m_we_d    = gnt & bus.d_we;
                m_addr_d  = gnt ? bus.d_addr : bus.if_addr;
                m_wdata_d = gnt ? bus.d_wdata : 32'd0;
                m_ctrl_d  = gnt ? bus.d_ctrl : 3'b000;
                owner_d   = gnt;
                last_d    = gnt;
                cnt_d     = '0;
            end
        end else if (state_q == BUSY) begin
            if (bus.m_ack | tmo) begin
                state_d    = DONE;
                m_req_d    = 1'b0;
                m_we_d     = 1'b0;
                err_d      = ~bus.m_ack;
                if_ready_d = ~owner_q;
                d_ready_d  = owner_q;
                if_rdata_d = owner_q ? if_rdata_q : (bus.m_ack ? bus.m_rdata : 32'd0);
                d_rdata_d  = ~owner_q ? d_rdata_q :
                             ~bus.m_ack ? 32'd0 : (m_we_q ? d_rdata_q : bus.m_rdata);
            end else begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_ctrl_q   <= '0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            owner_q    <= 1'b0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_ctrl_q   <= m_ctrl_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end
    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.m_ctrl   = m_ctrl_q;
    assign bus.if_ready = if_ready_q;
    assign bus.d_ready  = d_ready_q;
    assign bus.err      = err_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
endmodule

// File: tb/tb_pcpu_mem_arbiter.sv
// tb_pcpu_mem_arbiter: directed checks of the arbiter with a 4-cycle watchdog.
module tb_pcpu_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vec = 0;
    int   errs = 0;
    pcpu_mem_arbiter_if bus();
    pcpu_mem_arbiter #(.TIMEOUT(4), .CNT_W(3)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.d_ctrl = 0; bus.m_ack = 0; bus.m_rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        repeat (2) @(negedge clk);
        vec++;
        if ({bus.if_ready, bus.if_rdata, bus.d_ready, bus.d_rdata, bus.m_req, bus.m_we,
             bus.m_addr, bus.m_wdata, bus.m_ctrl, bus.err} !== 136'd0) begin
            errs++; $display("FAIL reset_outputs: m_req=%b m_addr=%h ready=%b%b err=%b", bus.m_req, bus.m_addr, bus.if_ready, bus.d_ready, bus.err);
        end
        reset = 0;
        @(negedge clk);
        vec++;
        if (bus.m_req !== 1'b0) begin errs++; $display("FAIL idle_no_req: m_req=%b want 0", bus.m_req); end
    endtask

    task automatic test_fetch();
        bus.if_req = 1; bus.if_addr = 32'h40;
        @(negedge clk);
        vec++;
        if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_ctrl} !== {1'b1, 1'b0, 32'h40, 32'h0, 3'b000}) begin
            errs++; $display("FAIL fetch_issue: req=%b we=%b addr=%h wdata=%h ctrl=%b want 1 0 00000040 0 000", bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_ctrl);
        end
        bus.m_ack = 1; bus.m_rdata = 32'h00500093;
        @(negedge clk);
        vec++;
        if ({bus.if_ready, bus.if_rdata, bus.d_ready, bus.m_req, bus.err} !== {1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0}) begin
            errs++; $display("FAIL fetch_done: if_ready=%b if_rdata=%h d_ready=%b m_req=%b err=%b want 1 00500093 0 0 0", bus.if_ready, bus.if_rdata, bus.d_ready, bus.m_req, bus.err);
        end
        bus.if_req = 0; bus.m_ack = 0;
        @(negedge clk);
        vec++;
        if ({bus.if_ready, bus.m_req} !== 2'b00) begin errs++; $display("FAIL fetch_after: if_ready=%b m_req=%b want 0 0", bus.if_ready, bus.m_req); end
    endtask

    task automatic test_load();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200; bus.d_ctrl = 3'b100; bus.d_wdata = 32'h55;
        @(negedge clk);
        vec++;
        if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_ctrl} !== {1'b1, 1'b0, 32'h200, 3'b100}) begin
            errs++; $display("FAIL load_issue: req=%b we=%b addr=%h ctrl=%b want 1 0 00000200 100", bus.m_req, bus.m_we, bus.m_addr, bus.m_ctrl);
        end
        bus.m_ack = 1; bus.m_rdata = 32'hCAFEF00D;
        @(negedge clk);
        vec++;
        if ({bus.d_ready, bus.d_rdata, bus.if_ready, bus.err} !== {1'b1, 32'hCAFEF00D, 1'b0, 1'b0}) begin
            errs++; $display("FAIL load_done: d_ready=%b d_rdata=%h if_ready=%b err=%b want 1 cafef00d 0 0", bus.d_ready, bus.d_rdata, bus.if_ready, bus.err);
        end
        bus.d_req = 0; bus.m_ack = 0;
        @(negedge clk);
    endtask

    task automatic test_store_wait();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF; bus.d_ctrl = 3'b010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++;
            if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_ctrl, bus.d_ready} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1'b0}) begin
                errs++; $display("FAIL store_busy%0d: req=%b we=%b addr=%h wdata=%h ctrl=%b d_ready=%b", i, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_ctrl, bus.d_ready);
            end
            bus.d_addr = 32'hBAD0_0000 + i; bus.d_wdata = 32'h1111_1111 * i; bus.if_req = 1;
            bus.m_ack = (i == 3); bus.m_rdata = 32'h12345678;
        end
        @(negedge clk);
        vec++;
        if ({bus.d_ready, bus.d_rdata, bus.m_req, bus.m_we, bus.err, bus.if_ready} !== {1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errs++; $display("FAIL store_done: d_ready=%b d_rdata=%h m_req=%b m_we=%b err=%b if_ready=%b want 1 cafef00d 0 0 0 0", bus.d_ready, bus.d_rdata, bus.m_req, bus.m_we, bus.err, bus.if_ready);
        end
        bus.d_req = 0; bus.if_req = 0; bus.m_ack = 0;
        @(negedge clk);
        vec++;
        if ({bus.d_ready, bus.m_req} !== 2'b00) begin errs++; $display("FAIL store_after: d_ready=%b m_req=%b want 0 0", bus.d_ready, bus.m_req); end
    endtask

    task automatic test_contention();
        logic exp_d;
        reset = 1;
        bus.if_req = 1; bus.if_addr = 32'h1000; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000; bus.d_ctrl = 3'b010;
        @(negedge clk);
        reset = 0;
        for (int g = 0; g < 4; g++) begin
            exp_d = (g % 2 == 0);
            @(negedge clk);
            vec++;
            if (bus.m_addr !== (exp_d ? 32'h2000 : 32'h1000)) begin
                errs++; $display("FAIL contention_grant%0d: m_addr=%h want %h", g, bus.m_addr, exp_d ? 32'h2000 : 32'h1000);
            end
            bus.m_ack = 1; bus.m_rdata = 32'hA000 + g;
            @(negedge clk);
            vec++;
            if ({bus.d_ready, bus.if_ready} !== {exp_d, ~exp_d}) begin
                errs++; $display("FAIL contention_ready%0d: d_ready=%b if_ready=%b want %b %b", g, bus.d_ready, bus.if_ready, exp_d, ~exp_d);
            end
            bus.m_ack = 0;
            @(negedge clk);
        end
        bus.if_req = 0; bus.d_req = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300; bus.d_ctrl = 3'b010; bus.m_ack = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++;
            if ({bus.m_req, bus.d_ready, bus.err} !== 3'b100) begin
                errs++; $display("FAIL timeout_busy%0d: m_req=%b d_ready=%b err=%b want 1 0 0", i, bus.m_req, bus.d_ready, bus.err);
            end
        end
        @(negedge clk);
        vec++;
        if ({bus.m_req, bus.d_ready, bus.err, bus.d_rdata} !== {1'b0, 1'b1, 1'b1, 32'd0}) begin
            errs++; $display("FAIL timeout_done: m_req=%b d_ready=%b err=%b d_rdata=%h want 0 1 1 0", bus.m_req, bus.d_ready, bus.err, bus.d_rdata);
        end
        bus.d_req = 0;
        @(negedge clk);
        vec++;
        if ({bus.d_ready, bus.err, bus.m_req} !== 3'b000) begin errs++; $display("FAIL timeout_after: d_ready=%b err=%b m_req=%b want 0 0 0", bus.d_ready, bus.err, bus.m_req); end
    endtask

    task automatic test_reset_mid();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400;
        @(negedge clk);
        @(negedge clk);
        vec++;
        if (bus.m_req !== 1'b1) begin errs++; $display("FAIL midreset_pre: m_req=%b want 1", bus.m_req); end
        reset = 1; bus.d_req = 0;
        #1;
        vec++;
        if ({bus.m_req, bus.m_addr} !== {1'b0, 32'd0}) begin errs++; $display("FAIL midreset_async: m_req=%b m_addr=%h want 0 0", bus.m_req, bus.m_addr); end
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++;
            if ({bus.m_req, bus.if_ready, bus.d_ready, bus.err} !== 4'b0000) begin
                errs++; $display("FAIL midreset_after%0d: m_req=%b if_ready=%b d_ready=%b err=%b want 0000", i, bus.m_req, bus.if_ready, bus.d_ready, bus.err);
            end
        end
    endtask

    task automatic test_stray_ack();
        bus.m_ack = 1; bus.m_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vec++;
            if ({bus.m_req, bus.if_ready, bus.d_ready, bus.err, bus.d_rdata} !== {4'b0000, 32'd0}) begin
                errs++; $display("FAIL stray_idle%0d: m_req=%b if_ready=%b d_ready=%b err=%b d_rdata=%h", i, bus.m_req, bus.if_ready, bus.d_ready, bus.err, bus.d_rdata);
            end
        end
        bus.if_req = 1; bus.if_addr = 32'h80; bus.m_rdata = 32'h0000_0013;
        @(negedge clk);
        @(negedge clk);
        vec++;
        if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'h13}) begin errs++; $display("FAIL stray_fetch: if_ready=%b if_rdata=%h want 1 00000013", bus.if_ready, bus.if_rdata); end
        bus.if_req = 0; bus.m_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vec++;
            if ({bus.m_req, bus.if_ready, bus.d_ready, bus.err, bus.if_rdata} !== {4'b0000, 32'h13}) begin
                errs++; $display("FAIL stray_done%0d: m_req=%b if_ready=%b d_ready=%b err=%b if_rdata=%h", i, bus.m_req, bus.if_ready, bus.d_ready, bus.err, bus.if_rdata);
            end
        end
        bus.m_ack = 0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load();
        test_store_wait();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_stray_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/pcpu_mem_arbiter.md
Name: pcpu_mem_arbiter

Overview:
Arbitrates a single shared memory port between the pipelined CPU's instruction-fetch requester and its data (load/store) requester. It sequences every access through an IDLE/BUSY/DONE handshake against a variable-latency memory. Round-robin on contention prevents either stage from starving the other, and a watchdog terminates accesses the memory never acknowledges. It sits between the CPU core (IF and MEM stages, which stall on their own `req & !ready`) and the unified instruction/data memory.

Parameters:
TIMEOUT, 16, BUSY cycles without m_ack before an access is aborted; 0 disables the watchdog.
CNT_W, 5, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held high until if_ready
if_addr  in  32  fetch address (PC)
if_ready  out  1  one-cycle completion pulse for fetch
if_rdata  out  32  fetched instruction, valid while if_ready=1
d_req  in  1  data request; held high until d_ready
d_we  in  1  1=store, 0=load
d_addr  in  32  data address (ALU result)
d_wdata  in  32  store data
d_ctrl  in  3  dm_ctrl access size/sign code, passed through unchanged
d_ready  out  1  one-cycle completion pulse for data
d_rdata  out  32  load data, valid while d_ready=1
m_req  out  1  memory request, high for the whole BUSY state
m_we  out  1  memory write enable
m_addr  out  32  memory address
m_wdata  out  32  memory write data
m_ctrl  out  3  memory access code (fetch issues word code 3'b000)
m_ack  in  1  memory completion, sampled only in BUSY
m_rdata  in  32  memory read data, valid with m_ack
err  out  1  one-cycle pulse in DONE when the access timed out

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE; m_req, m_we, if_ready, d_ready, err = 0; m_addr, m_wdata, if_rdata, d_rdata = 0; m_ctrl = 0; last_grant = IF; counter = 0. Reset acts immediately, including mid-access; a BUSY access is dropped and m_req falls asynchronously.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both requests: grant the requester opposite last_grant, so data wins the first tie after reset.
  - On grant: latch addr/we/wdata/ctrl into the m_* outputs, set m_req=1, record owner and last_grant, clear counter, go to BUSY.
  - A fetch grant drives m_we=0 and m_wdata=0.
- BUSY:
  - m_* outputs are held stable.
  - Requester inputs are ignored, so changes in them have no effect.
  - Counter increments each cycle m_ack=0.
  - On m_ack=1: capture m_rdata into the owner's rdata (loads and fetches only; stores leave d_rdata unchanged), drop m_req/m_we, go to DONE.
  - If TIMEOUT≠0 and counter reaches TIMEOUT-1 with m_ack=0: drop m_req, set owner rdata=0, go to DONE with err=1.
- DONE (exactly one cycle):
  - Owner's ready=1, plus err if the access timed out.
  - All requests are ignored this cycle, because the requester is still dropping req.
  - Next state is IDLE; ready and err return to 0.
- m_ack outside BUSY is ignored.
- Latency:
  - Request seen at edge N gives m_req high from cycle N+1.
  - Zero-wait memory (m_ack in the first BUSY cycle) gives ready in cycle N+2.
  - Back-to-back accesses run at 3 cycles each (IDLE, BUSY, DONE) minimum.
- if_ready and d_ready are never high in the same cycle.
- A new request arriving during BUSY/DONE waits; it is never lost as long as its req stays high.
- Counter saturates and does not wrap; with TIMEOUT=0 it is never compared.

Test Plan:
- Single fetch: if_req=1, if_addr=0x00000040, memory acks in 1st BUSY cycle with 0x00500093 -> m_req high 1 cycle, if_ready pulse 2 cycles after request, if_rdata=0x00500093, d_ready stays 0.
- Store with 3 wait states: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_ctrl=3'b010 -> m_* hold those values for 4 BUSY cycles, d_ready pulses once, d_rdata unchanged.
- Contention: if_req and d_req held high continuously from reset -> grants alternate D,IF,D,IF; no requester is granted twice in a row.
- Timeout: TIMEOUT=4, load with m_ack held 0 -> m_req high exactly 4 cycles, then d_ready=1, err=1, d_rdata=0 in the same cycle.
- Reset mid-access: assert reset during the 2nd BUSY cycle -> m_req=0 immediately; after release the arbiter is IDLE with no spurious ready or err pulse.
- Stray ack: m_ack pulsed while in IDLE and DONE -> no state change and no ready pulse.
